// File: rtl/argmax_classifier.sv
// argmax_classifier: snapshots a signed score vector on start, scans one element
// per cycle and presents the index/value of the largest score over valid/ready.
// Ties resolve to the lowest index. Optional feature macro ARGMAX_MARGIN_EN adds
// a second-best tracker that drives margin and low_conf; without it both are 0.
module argmax_classifier #(
  parameter int          N_CLASSES  = 10,
  parameter int          IDX_W      = $clog2(N_CLASSES),
  parameter logic [31:0] MARGIN_THR = 32'd256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [31:0]      score_vector [N_CLASSES-1:0],
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [IDX_W-1:0]        class_idx,
  output logic signed [31:0]      class_score,
  output logic [31:0]             margin,
  output logic                    low_conf
);

  localparam int DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] snap [N_CLASSES];
  logic signed [DATA_W-1:0] best;
  logic [IDX_W-1:0]         best_idx;
  logic [IDX_W-1:0]         ptr;

  logic signed [DATA_W-1:0] cand;
  logic signed [DATA_W-1:0] nxt_best;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     cand_gt_best;

  // best >= second always holds, so the 33-bit difference fits in 32 unsigned bits
  function automatic logic [DATA_W-1:0] calc_margin(input logic signed [DATA_W-1:0] hi,
                                                     input logic signed [DATA_W-1:0] lo);
    return DATA_W'($signed({hi[DATA_W-1], hi}) - $signed({lo[DATA_W-1], lo}));
  endfunction

  function automatic logic is_low_conf(input logic [DATA_W-1:0] m);
    return m < MARGIN_THR;
  endfunction

  // Compare the current element against the running best; strict > keeps the lowest index on ties
  always_comb begin
    cand         = snap[ptr];
    cand_gt_best = (cand > best);
    nxt_best     = cand_gt_best ? cand : best;
    nxt_idx      = cand_gt_best ? ptr  : best_idx;
  end

  // Control FSM: snapshot on start, one element per SCAN cycle, hold result until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      best         <= '0;
      best_idx     <= '0;
      ptr          <= '0;
      for (int i = 0; i < N_CLASSES; i++) snap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_CLASSES; i++) snap[i] <= score_vector[i];
            best     <= score_vector[0];
            best_idx <= '0;
            ptr      <= IDX_W'(1);
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= nxt_best;
          best_idx <= nxt_idx;
          if (ptr == LAST_IDX) begin
            class_idx    <= nxt_idx;
            class_score  <= nxt_best;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] second;
  logic signed [DATA_W-1:0] nxt_second;
  logic [DATA_W-1:0]        nxt_margin;

  // Second-best update: a displaced best becomes second, otherwise keep the larger of cand/second
  always_comb begin
    if (cand_gt_best)      nxt_second = best;
    else if (cand > second) nxt_second = cand;
    else                   nxt_second = second;
    nxt_margin = calc_margin(nxt_best, nxt_second);
  end

  // Second-best tracker and margin outputs, registered alongside the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second   <= '0;
      margin   <= '0;
      low_conf <= 1'b0;
    end else if (state == IDLE && start) begin
      second <= MOST_NEG;
    end else if (state == SCAN) begin
      second <= nxt_second;
      if (ptr == LAST_IDX) begin
        margin   <= nxt_margin;
        low_conf <= is_low_conf(nxt_margin);
      end
    end
  end
`else
  assign margin   = '0;
  assign low_conf = 1'b0;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier with a reference model built from
// "largest value, lowest index wins; margin = best minus largest of the rest".
module tb_argmax_classifier;

  localparam int N = 10;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [31:0] score_vector [N-1:0];
  logic               busy;
  logic               result_valid;
  logic               result_ready;
  logic [3:0]         class_idx;
  logic signed [31:0] class_score;
  logic [31:0]        margin;
  logic               low_conf;

  int total = 0;
  int bad   = 0;

  argmax_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .score_vector (score_vector),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_idx    (class_idx),
    .class_score  (class_score),
    .margin       (margin),
    .low_conf     (low_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first index of the maximum; second = max over all other positions
  task automatic model(input logic signed [31:0] v [N-1:0], output int idx,
                       output logic signed [31:0] bst, output logic [31:0] mrg,
                       output logic lc);
    logic signed [31:0] sec;
    longint d;
    idx = 0;
    bst = v[0];
    for (int i = 1; i < N; i++) if (v[i] > bst) begin bst = v[i]; idx = i; end
    sec = 32'sh8000_0000;
    for (int i = 0; i < N; i++) if (i != idx && v[i] > sec) sec = v[i];
    d = longint'(bst) - longint'(sec);
`ifdef ARGMAX_MARGIN_EN
    mrg = d[31:0];
    lc  = (mrg < 32'd256);
`else
    mrg = (d < 0) ? 32'd0 : 32'd0;
    lc  = 1'b0;
`endif
  endtask

  task automatic load_vec(input int vals [N]);
    for (int i = 0; i < N; i++) score_vector[i] = vals[i];
  endtask

  // Pulse start for one edge; returns positioned #1 after the start edge
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after the start edge until result_valid, bounded
  task automatic wait_result(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; result_ready = 1'b0;
    for (int i = 0; i < N; i++) score_vector[i] = 32'sd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    total++; if (class_idx !== 4'd0 || class_score !== 32'sd0) begin bad++;
      $display("FAIL reset_result: got idx=%0d score=%0d want 0/0", class_idx, class_score); end
    total++; if (margin !== 32'd0 || low_conf !== 1'b0) begin bad++;
      $display("FAIL reset_margin: got %0d/%b want 0/0", margin, low_conf); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_distinct();
    int vals [N] = '{5, 3, 90, 7, 1, 0, 12, 89, 4, 2};
    int lat;
    load_vec(vals);
    result_ready = 1'b1;
    do_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL distinct_busy_rise: got %b want 1", busy); end
    wait_result(lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL distinct_latency: got %0d want 9", lat); end
    total++; if (class_idx !== 4'd2 || class_score !== 32'sd90) begin bad++;
      $display("FAIL distinct_result: got idx=%0d score=%0d want 2/90", class_idx, class_score); end
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 32'd1 || low_conf !== 1'b1) begin bad++;
      $display("FAIL distinct_margin: got %0d/%b want 1/1", margin, low_conf); end
`else
    total++; if (margin !== 32'd0 || low_conf !== 1'b0) begin bad++;
      $display("FAIL distinct_margin_off: got %0d/%b want 0/0", margin, low_conf); end
`endif
    @(posedge clk); #1;
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL distinct_handshake: got valid=%b busy=%b want 0/0", result_valid, busy); end
    total++; if (class_idx !== 4'd2 || class_score !== 32'sd90) begin bad++;
      $display("FAIL distinct_hold: got idx=%0d score=%0d want 2/90", class_idx, class_score); end
  endtask

  task automatic test_tie_negative();
    int vals_t [N] = '{-4, 20, 20, -1, -5, -6, -7, -8, -2, -9};
    int vals_n [N] = '{-100, -3, -50, -7, -8, -9, -10, -11, -12, -13};
    int lat;
    load_vec(vals_t);
    do_start();
    wait_result(lat);
    total++; if (class_idx !== 4'd1 || class_score !== 32'sd20) begin bad++;
      $display("FAIL tie_result: got idx=%0d score=%0d want 1/20", class_idx, class_score); end
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 32'd0) begin bad++; $display("FAIL tie_margin: got %0d want 0", margin); end
`endif
    @(posedge clk); #1;
    load_vec(vals_n);
    do_start();
    wait_result(lat);
    total++; if (class_idx !== 4'd1 || class_score !== -32'sd3) begin bad++;
      $display("FAIL neg_result: got idx=%0d score=%0d want 1/-3", class_idx, class_score); end
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 32'd4) begin bad++; $display("FAIL neg_margin: got %0d want 4", margin); end
`endif
    @(posedge clk); #1;
  endtask

  // Score vector scrambled every cycle of the scan; result must follow the start-edge vector
  task automatic test_snapshot();
    logic signed [31:0] orig [N-1:0];
    int eidx, lat;
    logic signed [31:0] escore;
    logic [31:0] emrg;
    logic elc;
    for (int i = 0; i < N; i++) score_vector[i] = $urandom;
    orig = score_vector;
    model(orig, eidx, escore, emrg, elc);
    do_start();
    lat = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      for (int i = 0; i < N; i++) score_vector[i] = $urandom;
      score_vector[N-1] = 32'sh7fff_ffff;
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 9) begin bad++; $display("FAIL snap_latency: got %0d want 9", lat); end
    total++; if (class_idx !== 4'(eidx) || class_score !== escore || margin !== emrg || low_conf !== elc) begin bad++;
      $display("FAIL snap_result: got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b",
               class_idx, class_score, margin, low_conf, eidx, escore, emrg, elc); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int vals [N] = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
    int vals2 [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 99};
    int lat;
    result_ready = 1'b0;
    load_vec(vals);
    do_start();
    wait_result(lat);
    load_vec(vals2);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(posedge clk); #1;
      total++; if (result_valid !== 1'b1 || busy !== 1'b1 || class_idx !== 4'd4 || class_score !== 32'sd50) begin bad++;
        $display("FAIL bp_hold: cycle %0d got v=%b b=%b idx=%0d score=%0d want 1/1/4/50",
                 c, result_valid, busy, class_idx, class_score); end
    end
    // start held high across the handshake edge must not launch a new scan
    result_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (result_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL bp_release: got valid=%b busy=%b want 0/0", result_valid, busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_start_ignored: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_midscan();
    int vals [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7};
    int lat;
    for (int i = 0; i < N; i++) score_vector[i] = 32'sd100 + i;
    do_start();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || result_valid !== 1'b0) begin bad++;
      $display("FAIL midscan_abort: got busy=%b valid=%b want 0/0", busy, result_valid); end
    total++; if (class_idx !== 4'd0 || class_score !== 32'sd0) begin bad++;
      $display("FAIL midscan_clear: got idx=%0d score=%0d want 0/0", class_idx, class_score); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    load_vec(vals);
    do_start();
    wait_result(lat);
    total++; if (lat !== 9 || class_idx !== 4'd9 || class_score !== 32'sd7) begin bad++;
      $display("FAIL midscan_restart: got lat=%0d idx=%0d score=%0d want 9/9/7", lat, class_idx, class_score); end
    @(posedge clk); #1;
  endtask

  task automatic test_margin_thr();
    int vals [N] = '{10, 700, 5, 3, 1000, 2, -8, 699, 0, 1};
    int lat;
    load_vec(vals);
    do_start();
    wait_result(lat);
    total++; if (class_idx !== 4'd4 || class_score !== 32'sd1000) begin bad++;
      $display("FAIL thr_result: got idx=%0d score=%0d want 4/1000", class_idx, class_score); end
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 32'd300 || low_conf !== 1'b0) begin bad++;
      $display("FAIL thr_margin: got %0d/%b want 300/0", margin, low_conf); end
`else
    total++; if (margin !== 32'd0 || low_conf !== 1'b0) begin bad++;
      $display("FAIL thr_margin_off: got %0d/%b want 0/0", margin, low_conf); end
`endif
    @(posedge clk); #1;
  endtask

  // Back-to-back random vectors: narrow ranges force ties, wide ranges stress sign handling
  task automatic test_back_to_back();
    int eidx, lat;
    logic signed [31:0] escore;
    logic [31:0] emrg;
    logic elc;
    logic signed [31:0] v [N-1:0];
    result_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t % 3 == 0) v[i] = int'($urandom_range(0, 7)) - 4;
        else if (t % 3 == 1) v[i] = $urandom;
        else v[i] = (i % 2) ? 32'sh8000_0000 : 32'sh7fff_ffff - int'($urandom_range(0, 1));
      end
      score_vector = v;
      model(v, eidx, escore, emrg, elc);
      do_start();
      wait_result(lat);
      total++; if (lat !== 9 || class_idx !== 4'(eidx) || class_score !== escore || margin !== emrg || low_conf !== elc) begin bad++;
        $display("FAIL rand_%0d: got lat=%0d %0d/%0d/%0d/%b want 9 %0d/%0d/%0d/%b",
                 t, lat, class_idx, class_score, margin, low_conf, eidx, escore, emrg, elc); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_tie_negative();
    test_snapshot();
    test_backpressure();
    test_reset_midscan();
    test_margin_thr();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
